instr_encoder: RTL and testbench

- Encodes decoded instruction requests (op class plus fields) into 32-bit MIPS words for the single-cycle CPU's supported subset: R-type, LW, SW, BEQ, ADDI and J.
- Writes the encoded words sequentially into instruction memory through a stallable write port.
- This is the encoder counterpart of the opcode control decoder, used by the boot loader and the test harness to build programs.
- Has a one-entry output stage, an address counter and a small run/full state machine.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_pack.sv | 25 ++
 rtl/instr_encoder.sv | 122 ++++++++++++
 tb/tb_instr_encoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: op classes, MIPS opcodes and encoder state.
package cpu_pkg;

    localparam int unsigned OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_R    = 3'd0;
    localparam logic [OPC_W-1:0] OPC_LW   = 3'd1;
    localparam logic [OPC_W-1:0] OPC_SW   = 3'd2;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 3'd3;
    localparam logic [OPC_W-1:0] OPC_ADDI = 3'd4;
    localparam logic [OPC_W-1:0] OPC_J    = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS field packer; legal is low for op classes 6 and 7.
module instr_pack
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] op_class,
    input  instr_fields_t    fields,
    output logic [31:0]      word,
    output logic             legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op_class)
            OPC_R:    word = {OP_R, fields.rs, fields.rt, fields.rd, 5'b0, fields.funct};
            OPC_LW:   word = {OP_LW, fields.rs, fields.rt, fields.imm};
            OPC_SW:   word = {OP_SW, fields.rs, fields.rt, fields.imm};
            OPC_BEQ:  word = {OP_BEQ, fields.rs, fields.rt, fields.imm};
            OPC_ADDI: word = {OP_ADDI, fields.rs, fields.rt, fields.imm};
            OPC_J:    word = {OP_J, fields.target};
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests and writes them sequentially into instruction
// memory through a one-entry stallable output stage.
module instr_encoder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  op_class,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    enc_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    instr_fields_t fields;
    logic [31:0]   packed_word;
    logic          packed_legal;
    logic          wr_done;
    logic          at_last;
    logic          accept;

    assign fields = '{rs: rs, rt: rt, rd: rd, funct: funct, imm: imm, target: target};

    instr_pack u_pack (
        .op_class (op_class),
        .fields   (fields),
        .word     (packed_word),
        .legal    (packed_legal)
    );

    // A completion at the last address cannot take a new word, so ready is withheld.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wr_done  = we_q & imem_ready;
        at_last  = (addr_q == LAST_ADDR);
        in_ready = (state_q == ST_RUN) & ~start & (~we_q | (imem_ready & ~at_last));
        accept   = in_valid & in_ready;

        if (start) begin
            state_d = ST_RUN;
            we_d    = 1'b0;
            addr_d  = base_addr;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            if (wr_done) begin
                we_d  = 1'b0;
                cnt_d = cnt_q + CNT_W'(1);
                if (at_last) begin
                    state_d = ST_FULL;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            if (accept) begin
                if (packed_legal) begin
                    we_d    = 1'b1;
                    wdata_d = packed_word;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_cnt   = cnt_q;
    assign full       = (state_q == ST_FULL);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios then random traffic
// against a cycle-level reference model and a written-memory scoreboard.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_class;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_cnt;
    logic              full;
    logic              err;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_class   (op_class),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .funct      (funct),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_cnt   (word_cnt),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: running/full flags, one pending word, next address, count.
    bit          m_run, m_full, m_pend, m_err;
    int unsigned m_addr, m_cnt;
    logic [31:0] m_data;
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] obs_mem [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_encode(input int unsigned opc, input int unsigned f_rs,
                                               input int unsigned f_rt, input int unsigned f_rd,
                                               input int unsigned f_funct, input int unsigned f_imm,
                                               input int unsigned f_tgt, output bit legal);
        int unsigned regs;
        regs  = f_rs * (1 << 21) + f_rt * (1 << 16);
        legal = 1'b1;
        case (opc)
            0: return regs + f_rd * (1 << 11) + f_funct;
            1: return 32'h23 * (1 << 26) + regs + f_imm;
            2: return 32'h2B * (1 << 26) + regs + f_imm;
            3: return 32'h04 * (1 << 26) + regs + f_imm;
            4: return 32'h08 * (1 << 26) + regs + f_imm;
            5: return 32'h02 * (1 << 26) + f_tgt;
            default: begin
                legal = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    // Inputs are already driven (after a negedge); check, step the model across one edge.
    task automatic cyc();
        bit          exp_rdy, acc, done, legal;
        logic [31:0] w;
        #1;
        exp_rdy = m_run && !start && (!m_pend || (imem_ready && m_addr != DEPTH - 1));
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("imem_we", 32'(imem_we), 32'(m_pend));
        check_eq("imem_addr", 32'(imem_addr), m_addr);
        check_eq("word_cnt", 32'(word_cnt), m_cnt);
        check_eq("full", 32'(full), 32'(m_full));
        check_eq("err", 32'(err), 32'(m_err));
        if (m_pend) check_eq("imem_wdata", imem_wdata, m_data);
        acc  = in_valid && exp_rdy;
        w    = ref_encode(op_class, rs, rt, rd, funct, imm, target, legal);
        done = m_pend && imem_ready;
        if (rst_n && !start && imem_we && imem_ready && imem_addr < DEPTH)
            obs_mem[imem_addr] = imem_wdata;
        @(posedge clk);
        if (!rst_n) begin
            m_run = 0; m_full = 0; m_pend = 0; m_err = 0;
            m_addr = 0; m_cnt = 0; m_data = '0;
        end else if (start) begin
            m_run = 1; m_full = 0; m_pend = 0; m_err = 0;
            m_addr = base_addr; m_cnt = 0;
        end else begin
            if (done) begin
                exp_mem[m_addr] = m_data;
                m_cnt++;
                m_pend = 0;
                if (m_addr == DEPTH - 1) begin
                    m_run  = 0;
                    m_full = 1;
                end else begin
                    m_addr++;
                end
            end
            if (acc) begin
                if (legal) begin
                    m_pend = 1;
                    m_data = w;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input int unsigned opc, input int unsigned f_rs, input int unsigned f_rt,
                         input int unsigned f_rd, input int unsigned f_funct,
                         input int unsigned f_imm, input int unsigned f_tgt);
        in_valid = 1'b1;
        op_class = 3'(opc);
        rs       = 5'(f_rs);
        rt       = 5'(f_rt);
        rd       = 5'(f_rd);
        funct    = 6'(f_funct);
        imm      = 16'(f_imm);
        target   = 26'(f_tgt);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0;
            obs_mem[i] = '0;
        end
        m_run = 0; m_full = 0; m_pend = 0; m_err = 0;
        m_addr = 0; m_cnt = 0; m_data = '0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        op_class = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0; target = '0;
        imem_ready = 1'b0;
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        check_eq("rst_we", 32'(imem_we), 32'h0);
        check_eq("rst_addr", 32'(imem_addr), 32'h0);
        check_eq("rst_wdata", imem_wdata, 32'h0);
        check_eq("rst_cnt", 32'(word_cnt), 32'h0);
        check_eq("rst_full", 32'(full), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);

        // First word: ADDI into base 0x10
        start = 1'b1; base_addr = 8'h10;
        cyc();
        start = 1'b0;
        drive(4, 0, 8, 0, 0, 5, 0);
        cyc();
        in_valid = 1'b0;
        check_eq("addi_we", 32'(imem_we), 32'h1);
        check_eq("addi_addr", 32'(imem_addr), 32'h10);
        check_eq("addi_word", imem_wdata, 32'h20080005);
        imem_ready = 1'b1;
        cyc();
        check_eq("addi_cnt", 32'(word_cnt), 32'h1);
        check_eq("addi_next_addr", 32'(imem_addr), 32'h11);

        // Back-to-back LW, SW, R with memory always ready
        drive(1, 29, 8, 0, 0, 4, 0);
        cyc();
        drive(2, 29, 8, 0, 0, 8, 0);
        cyc();
        drive(0, 9, 10, 8, 32'h20, 0, 0);
        cyc();
        in_valid = 1'b0;
        cyc();
        check_eq("b2b_cnt", 32'(word_cnt), 32'h4);
        check_eq("b2b_addr", 32'(imem_addr), 32'h14);
        check_eq("lw_word", obs_mem[8'h11], 32'h8FA80004);
        check_eq("sw_word", obs_mem[8'h12], 32'hAFA80008);
        check_eq("r_word", obs_mem[8'h13], 32'h012A4020);

        // Stall a BEQ for three cycles with the next request waiting
        imem_ready = 1'b0;
        drive(3, 8, 9, 0, 0, 32'hFFFF, 0);
        cyc();
        drive(4, 1, 2, 0, 0, 3, 0);
        repeat (3) begin
            #1;
            check_eq("stall_ready", 32'(in_ready), 32'h0);
            check_eq("stall_word", imem_wdata, 32'h1109FFFF);
            check_eq("stall_addr", 32'(imem_addr), 32'h14);
            cyc();
        end
        imem_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        check_eq("beq_word", obs_mem[8'h14], 32'h1109FFFF);
        check_eq("stall_cnt", 32'(word_cnt), 32'h6);

        // Fill the last two addresses, third request must be refused
        start = 1'b1; base_addr = 8'(DEPTH - 2);
        cyc();
        start = 1'b0;
        drive(5, 0, 0, 0, 0, 32'h10, 32'h10);
        cyc();
        cyc();
        cyc();
        #1;
        check_eq("full_flag", 32'(full), 32'h1);
        check_eq("full_ready", 32'(in_ready), 32'h0);
        check_eq("full_cnt", 32'(word_cnt), 32'h2);
        check_eq("full_we", 32'(imem_we), 32'h0);
        cyc();
        in_valid = 1'b0;
        check_eq("j_word_lo", obs_mem[DEPTH - 2], 32'h08000010);
        check_eq("j_word_hi", obs_mem[DEPTH - 1], 32'h08000010);
        check_eq("full_no_wrap", 32'(imem_addr), 32'(DEPTH - 1));

        // Illegal op class sets err without writing; start clears it
        start = 1'b1; base_addr = 8'h05;
        cyc();
        start = 1'b0;
        drive(7, 1, 2, 3, 4, 5, 6);
        cyc();
        in_valid = 1'b0;
        check_eq("ill_err", 32'(err), 32'h1);
        check_eq("ill_we", 32'(imem_we), 32'h0);
        check_eq("ill_cnt", 32'(word_cnt), 32'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("ill_err_clr", 32'(err), 32'h0);

        // Drop a stalled word with start, then with reset
        imem_ready = 1'b0;
        drive(4, 3, 3, 0, 0, 32'h1234, 0);
        cyc();
        in_valid = 1'b0;
        start = 1'b1; base_addr = 8'h09;
        cyc();
        start = 1'b0;
        check_eq("drop_start_we", 32'(imem_we), 32'h0);
        imem_ready = 1'b1;
        repeat (3) cyc();
        check_eq("drop_start_cnt", 32'(word_cnt), 32'h0);
        check_eq("drop_start_mem", obs_mem[5], 32'h0);
        imem_ready = 1'b0;
        drive(4, 4, 4, 0, 0, 32'h5678, 0);
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_eq("drop_rst_we", 32'(imem_we), 32'h0);
        imem_ready = 1'b1;
        repeat (3) cyc();
        check_eq("drop_rst_mem", obs_mem[9], 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst_n      = ($urandom % 250) != 0;
            start      = ($urandom % 40) == 0;
            base_addr  = 8'($urandom % DEPTH);
            in_valid   = ($urandom % 10) < 7;
            op_class   = 3'($urandom);
            rs         = 5'($urandom);
            rt         = 5'($urandom);
            rd         = 5'($urandom);
            funct      = 6'($urandom);
            imm        = 16'($urandom);
            target     = 26'($urandom);
            imem_ready = ($urandom % 10) < 6;
            cyc();
        end

        for (int i = 0; i < DEPTH; i++) check_eq("mem_image", obs_mem[i], exp_mem[i]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
